// File: rtl/i2s_capture_reader.sv
// I2S receive side for the DAC-bound stream: deserializes stereo samples,
// strobes per-channel PCM, and queues complete L/R pairs for byte-wide readback.
module i2s_capture_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  capture_en,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    input  logic                  clear_ovf,
    input  logic                  rd_pop,
    input  logic [2:0]            rd_sel,
    output logic [7:0]            rd_data,
    output logic                  l_valid,
    output logic                  r_valid,
    output logic [DATA_WIDTH-1:0] l_pcm,
    output logic [DATA_WIDTH-1:0] r_pcm,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic [7:0]            frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DELAY,
        ST_SHIFT,
        ST_WAIT
    } state_t;

    // Input synchronizer and bit-clock edge detect
    logic r_b1, r_b2, r_lr1, r_sd1;
    logic r_lr_prev, r_prev_ok;
    logic w_rise, w_lr_chg;

    // Receiver
    state_t                r_state;
    logic                  r_ch;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_done_l, r_done_r;

    // Output strobes and held samples
    logic                  r_l_valid, r_r_valid;
    logic [DATA_WIDTH-1:0] r_l_pcm, r_r_pcm;

    // Pair FIFO
    logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [AW:0]             r_count;
    logic                    r_empty, r_full, r_ovf, r_left_ok;
    logic [7:0]              r_frame_cnt;
    logic [7:0]              r_rd_data;
    logic                    w_pop, w_push_req, w_push, w_ovf_set;
    logic [AW:0]             w_count_nxt;
    logic [2*DATA_WIDTH-1:0] w_head;
    logic [23:0]             w_head_l, w_head_r;

    assign w_rise   = r_b1 & ~r_b2;
    assign w_lr_chg = w_rise & r_prev_ok & (r_lr1 != r_lr_prev);

    // NOTE: every clocked block uses <= so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_b1      <= 1'b0;
            r_b2      <= 1'b0;
            r_lr1     <= 1'b0;
            r_sd1     <= 1'b0;
            r_lr_prev <= 1'b0;
            r_prev_ok <= 1'b0;
        end else begin
            r_b1  <= bclk;
            r_b2  <= r_b1;
            r_lr1 <= lrclk;
            r_sd1 <= sdata;
            // lrclk history is kept even while idle so SYNC can lock on the next change
            if (w_rise) begin
                r_lr_prev <= r_lr1;
                r_prev_ok <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ch      <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_done_l  <= 1'b0;
            r_done_r  <= 1'b0;
        end else begin
            r_done_l <= 1'b0;
            r_done_r <= 1'b0;
            if (!capture_en) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_SYNC;
                    ST_SYNC: begin
                        if (w_lr_chg) begin
                            r_ch    <= r_lr1;
                            r_state <= ST_DELAY;
                        end
                    end
                    // The change-detecting rise carried the delay-slot bit; arm for the MSB.
                    ST_DELAY: begin
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_lr_chg) begin
                            r_ch    <= r_lr1;
                            r_state <= ST_DELAY;
                        end else if (w_rise) begin
                            r_shift <= {r_shift[DATA_WIDTH-2:0], r_sd1};
                            if (r_bit_cnt == BIT_LAST) begin
                                r_done_l <= ~r_ch;
                                r_done_r <= r_ch;
                                r_state  <= ST_WAIT;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BIT_ONE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (w_lr_chg) begin
                            r_ch    <= r_lr1;
                            r_state <= ST_DELAY;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_l_valid <= 1'b0;
            r_r_valid <= 1'b0;
            r_l_pcm   <= '0;
            r_r_pcm   <= '0;
        end else begin
            r_l_valid <= r_done_l & capture_en;
            r_r_valid <= r_done_r & capture_en;
            if (r_done_l && capture_en) r_l_pcm <= r_shift;
            if (r_done_r && capture_en) r_r_pcm <= r_shift;
        end
    end

    assign w_pop      = rd_pop & ~r_empty;
    assign w_push_req = capture_en & r_r_valid & r_left_ok;
    assign w_push     = w_push_req & (~r_full | w_pop);
    assign w_ovf_set  = w_push_req & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_ovf       <= 1'b0;
            r_left_ok   <= 1'b0;
            r_frame_cnt <= '0;
        end else if (!capture_en) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_ovf       <= 1'b0;
            r_left_ok   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PTR_ONE;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_FULL);
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
            if (r_r_valid) begin
                r_left_ok <= 1'b0;
            end else if (r_l_valid) begin
                r_left_ok <= 1'b1;
            end
        end
    end

    // NOTE: storage array has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_l_pcm, r_r_pcm};
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign w_head_l = 24'(w_head[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign w_head_r = 24'(w_head[DATA_WIDTH-1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (!capture_en || r_empty) begin
            r_rd_data <= '0;
        end else begin
            case (rd_sel)
                3'd0:    r_rd_data <= w_head_l[7:0];
                3'd1:    r_rd_data <= w_head_l[15:8];
                3'd2:    r_rd_data <= w_head_l[23:16];
                3'd3:    r_rd_data <= w_head_r[7:0];
                3'd4:    r_rd_data <= w_head_r[15:8];
                3'd5:    r_rd_data <= w_head_r[23:16];
                default: r_rd_data <= '0;
            endcase
        end
    end

    assign rd_data     = r_rd_data;
    assign l_valid     = r_l_valid;
    assign r_valid     = r_r_valid;
    assign l_pcm       = r_l_pcm;
    assign r_pcm       = r_r_pcm;
    assign fifo_empty  = r_empty;
    assign fifo_full   = r_full;
    assign overflow    = r_ovf;
    assign frame_count = r_frame_cnt;

endmodule
